// File: rtl/bus_uart_pkg.sv
// Shared register map, STATUS bit positions and shifter state encoding for bus_uart_tx.
`default_nettype none

package bus_uart_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV_LO = 2'd2;
    localparam logic [1:0] OFF_DIV_HI = 2'd3;

    localparam int ST_FULL_BIT   = 0;
    localparam int ST_EMPTY_BIT  = 1;
    localparam int ST_ACTIVE_BIT = 2;
    localparam int ST_OVR_BIT    = 3;
    localparam int ST_IE_BIT     = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push into a full FIFO is accepted when a pop happens on the same edge.
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_uart.sv
// Memory-mapped UART transmitter: 4-byte register window, byte FIFO and 8N1 shifter.
`default_nettype none

module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'hD000,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [7:0]  data_write,
    input  logic        read_write,
    output logic [7:0]  data_read,
    output logic        sel,
    output logic        tx,
    output logic        irq
);

    logic [15:0] offset;
    logic [1:0]  reg_off;
    logic        wr_data;
    logic        wr_status;
    logic        wr_div_lo;
    logic        wr_div_hi;
    logic [15:0] divisor;
    logic [15:0] bit_div;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        ovr;
    logic        ie;
    logic        bit_end;
    logic [7:0]  status;
    tx_state_t   state;
    tx_state_t   state_next;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    assign offset    = address - BASE;
    assign sel       = (offset < 16'd4);
    assign reg_off   = offset[1:0];
    assign wr_data   = sel && read_write && (reg_off == OFF_DATA);
    assign wr_status = sel && read_write && (reg_off == OFF_STATUS);
    assign wr_div_lo = sel && read_write && (reg_off == OFF_DIV_LO);
    assign wr_div_hi = sel && read_write && (reg_off == OFF_DIV_HI);
    assign fifo_push = wr_data && (!fifo_full || fifo_pop);
    assign bit_end   = (baud_cnt >= bit_div);
    assign irq       = ie && fifo_empty && (state == TX_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_write),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status                = 8'h00;
        status[ST_FULL_BIT]   = fifo_full;
        status[ST_EMPTY_BIT]  = fifo_empty;
        status[ST_ACTIVE_BIT] = (state != TX_IDLE);
        status[ST_OVR_BIT]    = ovr;
        status[ST_IE_BIT]     = ie;
        data_read             = 8'h00;
        if (sel) begin
            case (reg_off)
                OFF_STATUS: data_read = status;
                OFF_DIV_LO: data_read = divisor[7:0];
                OFF_DIV_HI: data_read = divisor[15:8];
                default:    data_read = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr     <= 1'b0;
            ie      <= 1'b0;
            divisor <= DIV_RESET;
        end else begin
            if (wr_data && fifo_full && !fifo_pop) begin
                ovr <= 1'b1;
            end else if (wr_status && data_write[ST_OVR_BIT]) begin
                ovr <= 1'b0;
            end
            if (wr_status) begin
                ie <= data_write[ST_IE_BIT];
            end
            if (wr_div_lo) begin
                divisor[7:0] <= data_write;
            end
            if (wr_div_hi) begin
                divisor[15:8] <= data_write;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx         = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                tx = shreg[0];
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit so queued bytes go out with no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = TX_START;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // The divisor is sampled into bit_div at each bit boundary so a mid-frame write never stretches the current bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= 8'h00;
            baud_cnt <= 16'd0;
            bit_div  <= DIV_RESET;
            bit_cnt  <= 3'd0;
        end else if (fifo_pop) begin
            shreg    <= fifo_dout;
            baud_cnt <= 16'd0;
            bit_div  <= divisor;
            bit_cnt  <= 3'd0;
        end else if (state != TX_IDLE) begin
            if (bit_end) begin
                baud_cnt <= 16'd0;
                bit_div  <= divisor;
                if (state == TX_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
